snake_body_engine: RTL and testbench

- Parametrised next-generation snake movement engine for the VGA snake game.
- Holds up to MAX_LEN body segments on a GRID_W x GRID_H cell grid and advances them every STEP_TICKS clocks.
- Buffers direction requests (rejects 180-degree reversals), handles grow requests and detects wall and self collisions.
- Answers registered per-cell queries for the pixel renderer; sits between the key debouncer / game FSM and the VGA colour mux.

---
 rtl/snake_pkg.sv | 37 +++
 rtl/snake_step_timer.sv | 30 +++
 rtl/snake_body_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_snake_body_engine.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared encodings for the snake movement engine: directions, query cell
// classes, run states and the 180-degree reversal helper.
`timescale 1ns/1ps
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    CELL_NONE = 2'b00,
    CELL_HEAD = 2'b01,
    CELL_BODY = 2'b10,
    CELL_WALL = 2'b11
  } cell_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DEAD   = 2'b11
  } run_state_e;

  // Direction pointing the opposite way (up<->down, left<->right).
  function automatic dir_e opposite_dir(input dir_e d);
    case (d)
      DIR_UP:   return DIR_DOWN;
      DIR_DOWN: return DIR_UP;
      DIR_LEFT: return DIR_RIGHT;
      default:  return DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snake_step_timer.sv
// Step timer: counts enabled clocks and strobes o_step in the cycle the
// count reaches STEP_TICKS-1, wrapping back to zero in that same cycle.
`timescale 1ns/1ps
module snake_step_timer #(
  parameter int STEP_TICKS = 12500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_step
);

  localparam int CNT_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STEP_TICKS - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_step = i_en && (r_cnt == LP_LAST);

  // Tick counter: holds when disabled, wraps on the step cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_step ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/snake_body_engine.sv
// Snake movement engine: segment store, direction/grow buffering, wall and
// self collision, run-state FSM and registered per-cell query for the
// renderer. Optional head wrap-around: define SNAKE_BODY_ENGINE_WRAP_EN.
//
// dir_valid qualifies dir_req for exactly the cycle it is high; there is no
// back-pressure, so a request is either taken into the pending slot or
// discarded in the cycle it is presented. grow and start are likewise
// single-cycle pulses with no acknowledge.
`timescale 1ns/1ps
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int MAX_LEN    = 16,
  parameter int INIT_LEN   = 3,
  parameter int GRID_W     = 36,
  parameter int GRID_H     = 26,
  parameter int COORD_W    = 6,
  parameter int STEP_TICKS = 12500000,
  parameter int INIT_X     = 10,
  parameter int INIT_Y     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic [1:0]         dir_req,
  input  logic               dir_valid,
  input  logic               grow,
  input  logic               protect,
  input  logic [COORD_W-1:0] query_x,
  input  logic [COORD_W-1:0] query_y,
  output logic [1:0]         query_cell,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic [6:0]         length,
  output logic               step_pulse,
  output logic               hit_wall,
  output logic               hit_body,
  output logic [1:0]         run_state
);

  localparam logic [COORD_W-1:0] LP_X_LAST   = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] LP_Y_LAST   = COORD_W'(GRID_H - 1);
  localparam logic [6:0]         LP_MAX_LEN  = 7'(MAX_LEN);
  localparam logic [6:0]         LP_INIT_LEN = 7'(INIT_LEN);
`ifdef SNAKE_BODY_ENGINE_WRAP_EN
  localparam logic [COORD_W-1:0] LP_X_IN = COORD_W'(GRID_W - 2);
  localparam logic [COORD_W-1:0] LP_Y_IN = COORD_W'(GRID_H - 2);
`endif

  run_state_e         r_state, w_state_nxt;
  dir_e               r_dir, r_pend_dir, w_dir_eff, w_dir_ref, w_req;
  logic               r_pend_valid, r_grow_pend, r_step_pulse;
  logic               r_hit_wall, r_hit_body;
  logic [6:0]         r_len, w_body_lim;
  logic [COORD_W-1:0] r_seg_x [MAX_LEN];
  logic [COORD_W-1:0] r_seg_y [MAX_LEN];
  cell_e              r_query, w_query;
  logic               w_step, w_tmr_en, w_req_ok, w_growing;
  logic               w_wall_raw, w_body_raw, w_hit_wall, w_hit_body, w_collide;
  logic [COORD_W-1:0] w_nx, w_ny;

  assign w_tmr_en = (r_state == ST_RUN) && !pause && !start;

  snake_step_timer #(.STEP_TICKS(STEP_TICKS)) u_timer (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (w_tmr_en),
    .i_clr  (start),
    .o_step (w_step)
  );

  // Direction selection: pending request wins at a step; new requests are
  // judged against whatever direction will be committed after this cycle.
  always_comb begin
    w_dir_eff = r_pend_valid ? r_pend_dir : r_dir;
    w_dir_ref = w_step ? w_dir_eff : r_dir;
    w_req     = dir_e'(dir_req);
    w_req_ok  = dir_valid && (w_req != w_dir_ref) && (w_req != opposite_dir(w_dir_ref));
  end

  // Next head position and raw wall hit (clamped in place under protect).
  always_comb begin
    w_nx       = r_seg_x[0];
    w_ny       = r_seg_y[0];
    w_wall_raw = 1'b0;
`ifdef SNAKE_BODY_ENGINE_WRAP_EN
    case (w_dir_eff)
      DIR_UP:   w_ny = (r_seg_y[0] == COORD_W'(1)) ? LP_Y_IN : r_seg_y[0] - 1'b1;
      DIR_DOWN: w_ny = (r_seg_y[0] == LP_Y_IN) ? COORD_W'(1) : r_seg_y[0] + 1'b1;
      DIR_LEFT: w_nx = (r_seg_x[0] == COORD_W'(1)) ? LP_X_IN : r_seg_x[0] - 1'b1;
      default:  w_nx = (r_seg_x[0] == LP_X_IN) ? COORD_W'(1) : r_seg_x[0] + 1'b1;
    endcase
`else
    case (w_dir_eff)
      DIR_UP:   w_ny = r_seg_y[0] - 1'b1;
      DIR_DOWN: w_ny = r_seg_y[0] + 1'b1;
      DIR_LEFT: w_nx = r_seg_x[0] - 1'b1;
      default:  w_nx = r_seg_x[0] + 1'b1;
    endcase
    w_wall_raw = (w_nx == '0) || (w_nx == LP_X_LAST) || (w_ny == '0) || (w_ny == LP_Y_LAST);
    if (w_wall_raw && protect) begin
      w_nx = r_seg_x[0];
      w_ny = r_seg_y[0];
    end
`endif
  end

  // Self-collision: the tail cell is vacated on a normal step, kept when growing.
  always_comb begin
    w_growing  = r_grow_pend && (r_len < LP_MAX_LEN);
    w_body_lim = w_growing ? r_len : r_len - 7'd1;
    w_body_raw = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((7'(i) < w_body_lim) && (r_seg_x[i] == w_nx) && (r_seg_y[i] == w_ny)) begin
        w_body_raw = 1'b1;
      end
    end
    w_hit_wall = w_wall_raw && !protect;
    w_hit_body = w_body_raw && !protect && !w_wall_raw;
    w_collide  = w_hit_wall || w_hit_body;
  end

  // Run-state next-state logic; start overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_step && w_collide) w_state_nxt = ST_DEAD;
          else if (pause)          w_state_nxt = ST_PAUSED;
        end
        ST_PAUSED: if (!pause) w_state_nxt = ST_RUN;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  // Run-state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Snake body, direction, grow and collision flags; start reloads reset values.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= COORD_W'(INIT_X - i);
        r_seg_y[i] <= COORD_W'(INIT_Y);
      end
      r_len        <= LP_INIT_LEN;
      r_dir        <= DIR_RIGHT;
      r_pend_dir   <= DIR_UP;
      r_pend_valid <= 1'b0;
      r_grow_pend  <= 1'b0;
      r_step_pulse <= 1'b0;
      r_hit_wall   <= 1'b0;
      r_hit_body   <= 1'b0;
    end else begin
      r_step_pulse <= w_step;
      if (w_step) begin
        r_dir        <= w_dir_eff;
        r_pend_valid <= 1'b0;
        r_grow_pend  <= 1'b0;
      end
      if (w_req_ok) begin
        r_pend_valid <= 1'b1;
        r_pend_dir   <= w_req;
      end
      if (grow) r_grow_pend <= 1'b1;
      if (w_step) begin
        if (w_hit_wall) begin
          r_hit_wall <= 1'b1;
        end else if (w_hit_body) begin
          r_hit_body <= 1'b1;
        end else begin
          for (int i = 1; i < MAX_LEN; i++) begin
            r_seg_x[i] <= r_seg_x[i-1];
            r_seg_y[i] <= r_seg_y[i-1];
          end
          r_seg_x[0] <= w_nx;
          r_seg_y[0] <= w_ny;
          if (w_growing) r_len <= r_len + 7'd1;
        end
      end
    end
  end

  // Cell classification for the renderer: wall, then head, then body.
  always_comb begin
    w_query = CELL_NONE;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((7'(i) < r_len) && (r_seg_x[i] == query_x) && (r_seg_y[i] == query_y)) begin
        w_query = CELL_BODY;
      end
    end
    if ((r_seg_x[0] == query_x) && (r_seg_y[0] == query_y)) w_query = CELL_HEAD;
    if ((query_x == '0) || (query_x == LP_X_LAST) || (query_y == '0) || (query_y == LP_Y_LAST)) begin
      w_query = CELL_WALL;
    end
  end

  // Registered query answer, one cycle after the coordinates are presented.
  always_ff @(posedge clk) begin
    if (rst || start) r_query <= CELL_NONE;
    else              r_query <= w_query;
  end

  assign query_cell = r_query;
  assign head_x     = r_seg_x[0];
  assign head_y     = r_seg_y[0];
  assign length     = r_len;
  assign step_pulse = r_step_pulse;
  assign hit_wall   = r_hit_wall;
  assign hit_body   = r_hit_body;
  assign run_state  = r_state;

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine with STEP_TICKS=4. A second instance
// with MAX_LEN=4 shares all inputs and is only inspected for grow saturation.
`timescale 1ns/1ps
module tb_snake_body_engine;

  localparam logic [1:0] U = 2'b00, D = 2'b01, L = 2'b10, R = 2'b11;

  logic       clk = 1'b0;
  logic       rst, start, pause, dir_valid, grow, protect;
  logic [1:0] dir_req;
  logic [5:0] query_x, query_y;

  logic [1:0] query_cell, run_state;
  logic [5:0] head_x, head_y;
  logic [6:0] length;
  logic       step_pulse, hit_wall, hit_body;

  logic [1:0] s_query_cell, s_run_state;
  logic [5:0] s_head_x, s_head_y;
  logic [6:0] s_length;
  logic       s_step_pulse, s_hit_wall, s_hit_body;

  int n_cmp = 0;
  int n_bad = 0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  snake_body_engine #(.MAX_LEN(16), .STEP_TICKS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .dir_req(dir_req),
    .dir_valid(dir_valid), .grow(grow), .protect(protect), .query_x(query_x),
    .query_y(query_y), .query_cell(query_cell), .head_x(head_x), .head_y(head_y),
    .length(length), .step_pulse(step_pulse), .hit_wall(hit_wall),
    .hit_body(hit_body), .run_state(run_state)
  );

  snake_body_engine #(.MAX_LEN(4), .STEP_TICKS(4)) dut_s (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .dir_req(dir_req),
    .dir_valid(dir_valid), .grow(grow), .protect(protect), .query_x(query_x),
    .query_y(query_y), .query_cell(s_query_cell), .head_x(s_head_x), .head_y(s_head_y),
    .length(s_length), .step_pulse(s_step_pulse), .hit_wall(s_hit_wall),
    .hit_body(s_hit_body), .run_state(s_run_state)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One full step period starting right after a step (counter at 0).
  task automatic do_step(input logic dv, input logic [1:0] d, input logic g);
    dir_req = d; dir_valid = dv; grow = g;
    tick();
    dir_valid = 1'b0; grow = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0; dir_valid = 1'b0; dir_req = U;
    grow = 1'b0; protect = 1'b0; query_x = 6'd20; query_y = 6'd20;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (run_state !== 2'b00) begin n_bad++; $display("FAIL reset_state: got %0d want 0", run_state); end
    n_cmp++; if (length !== 7'd3) begin n_bad++; $display("FAIL reset_len: got %0d want 3", length); end
    n_cmp++; if (head_x !== 6'd10 || head_y !== 6'd5) begin n_bad++; $display("FAIL reset_head: got (%0d,%0d) want (10,5)", head_x, head_y); end
    n_cmp++; if (hit_wall !== 1'b0 || hit_body !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got %0d%0d want 00", hit_wall, hit_body); end
    n_cmp++; if (step_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %0d want 0", step_pulse); end
    n_cmp++; if (query_cell !== 2'b00) begin n_bad++; $display("FAIL reset_query: got %0d want 0", query_cell); end
    repeat (8) tick();
    n_cmp++; if (head_x !== 6'd10 || step_pulse !== 1'b0) begin n_bad++; $display("FAIL idle_hold: got x=%0d p=%0d want x=10 p=0", head_x, step_pulse); end
  endtask

  task automatic test_query();
    query_x = 6'd0; query_y = 6'd7; tick();
    n_cmp++; if (query_cell !== 2'b11) begin n_bad++; $display("FAIL q_wall: got %0d want 3", query_cell); end
    query_x = 6'd10; query_y = 6'd5;
    n_cmp++; if (query_cell !== 2'b11) begin n_bad++; $display("FAIL q_latency: got %0d want 3", query_cell); end
    tick();
    n_cmp++; if (query_cell !== 2'b01) begin n_bad++; $display("FAIL q_head: got %0d want 1", query_cell); end
    query_x = 6'd8; query_y = 6'd5; tick();
    n_cmp++; if (query_cell !== 2'b10) begin n_bad++; $display("FAIL q_seg2: got %0d want 2", query_cell); end
    query_x = 6'd7; query_y = 6'd5; tick();
    n_cmp++; if (query_cell !== 2'b00) begin n_bad++; $display("FAIL q_past_tail: got %0d want 0", query_cell); end
    query_x = 6'd20; query_y = 6'd20; tick();
    n_cmp++; if (query_cell !== 2'b00) begin n_bad++; $display("FAIL q_none: got %0d want 0", query_cell); end
    query_x = 6'd35; query_y = 6'd3; tick();
    n_cmp++; if (query_cell !== 2'b11) begin n_bad++; $display("FAIL q_right_wall: got %0d want 3", query_cell); end
    query_x = 6'd20; query_y = 6'd20;
  endtask

  task automatic test_run_basic();
    int pulses;
    do_start();
    n_cmp++; if (run_state !== 2'b01) begin n_bad++; $display("FAIL start_run: got %0d want 1", run_state); end
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (step_pulse === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 4) begin n_bad++; $display("FAIL step_pulses: got %0d want 4", pulses); end
    n_cmp++; if (head_x !== 6'd14 || head_y !== 6'd5) begin n_bad++; $display("FAIL basic_head: got (%0d,%0d) want (14,5)", head_x, head_y); end
    n_cmp++; if (length !== 7'd3 || run_state !== 2'b01) begin n_bad++; $display("FAIL basic_len_state: got %0d/%0d want 3/1", length, run_state); end
  endtask

  task automatic test_dir_filter();
    do_step(1'b1, L, 1'b0);
    n_cmp++; if (head_x !== 6'd15 || head_y !== 6'd5) begin n_bad++; $display("FAIL reverse_ignored: got (%0d,%0d) want (15,5)", head_x, head_y); end
    dir_req = U; dir_valid = 1'b1; tick();
    dir_req = D; tick();
    dir_valid = 1'b0; tick(); tick();
    n_cmp++; if (head_x !== 6'd15 || head_y !== 6'd6) begin n_bad++; $display("FAIL overwrite_down: got (%0d,%0d) want (15,6)", head_x, head_y); end
    pause = 1'b1; tick();
    n_cmp++; if (run_state !== 2'b10) begin n_bad++; $display("FAIL pause_state: got %0d want 2", run_state); end
    repeat (8) tick();
    n_cmp++; if (head_y !== 6'd6) begin n_bad++; $display("FAIL pause_freeze: got y=%0d want 6", head_y); end
    pause = 1'b0; tick();
    n_cmp++; if (run_state !== 2'b01) begin n_bad++; $display("FAIL resume_state: got %0d want 1", run_state); end
    repeat (3) tick();
    n_cmp++; if (head_y !== 6'd6) begin n_bad++; $display("FAIL resume_early: got y=%0d want 6", head_y); end
    tick();
    n_cmp++; if (head_y !== 6'd7) begin n_bad++; $display("FAIL resume_step: got y=%0d want 7", head_y); end
  endtask

  task automatic test_grow();
    do_start();
    grow = 1'b1; tick(); tick(); tick();
    grow = 1'b0; tick();
    n_cmp++; if (length !== 7'd4 || s_length !== 7'd4) begin n_bad++; $display("FAIL grow_once: got %0d/%0d want 4/4", length, s_length); end
    do_step(1'b0, U, 1'b1);
    n_cmp++; if (length !== 7'd5) begin n_bad++; $display("FAIL grow_twice: got %0d want 5", length); end
    n_cmp++; if (s_length !== 7'd4) begin n_bad++; $display("FAIL grow_saturate: got %0d want 4", s_length); end
    do_step(1'b0, U, 1'b0);
    n_cmp++; if (length !== 7'd5 || head_x !== 6'd13) begin n_bad++; $display("FAIL grow_cleared: got len=%0d x=%0d want 5/13", length, head_x); end
    pause = 1'b1; query_x = 6'd9; query_y = 6'd5; tick();
    n_cmp++; if (query_cell !== 2'b10) begin n_bad++; $display("FAIL q_tail: got %0d want 2", query_cell); end
    query_x = 6'd8; tick();
    n_cmp++; if (query_cell !== 2'b00) begin n_bad++; $display("FAIL q_vacated: got %0d want 0", query_cell); end
    query_x = 6'd13; tick();
    n_cmp++; if (query_cell !== 2'b01) begin n_bad++; $display("FAIL q_new_head: got %0d want 1", query_cell); end
    query_x = 6'd20; query_y = 6'd20;
    pause = 1'b0; tick();
  endtask

  task automatic test_body_hit();
    do_step(1'b1, U, 1'b0);
    n_cmp++; if (head_x !== 6'd13 || head_y !== 6'd4) begin n_bad++; $display("FAIL turn_up: got (%0d,%0d) want (13,4)", head_x, head_y); end
    do_step(1'b1, L, 1'b0);
    n_cmp++; if (head_x !== 6'd12 || head_y !== 6'd4) begin n_bad++; $display("FAIL turn_left: got (%0d,%0d) want (12,4)", head_x, head_y); end
    do_step(1'b1, D, 1'b0);
    n_cmp++; if (hit_body !== 1'b1 || hit_wall !== 1'b0) begin n_bad++; $display("FAIL body_flags: got w=%0d b=%0d want w=0 b=1", hit_wall, hit_body); end
    n_cmp++; if (run_state !== 2'b11) begin n_bad++; $display("FAIL body_dead: got %0d want 3", run_state); end
    n_cmp++; if (head_x !== 6'd12 || head_y !== 6'd4 || length !== 7'd5) begin n_bad++; $display("FAIL body_hold: got (%0d,%0d) len %0d want (12,4) len 5", head_x, head_y, length); end
    repeat (8) tick();
    n_cmp++; if (run_state !== 2'b11 || head_y !== 6'd4) begin n_bad++; $display("FAIL dead_stays: got st=%0d y=%0d want 3/4", run_state, head_y); end
    do_start();
    n_cmp++; if (length !== 7'd3 || head_x !== 6'd10 || head_y !== 6'd5) begin n_bad++; $display("FAIL restart_pos: got (%0d,%0d) len %0d want (10,5) len 3", head_x, head_y, length); end
    n_cmp++; if (hit_body !== 1'b0 || hit_wall !== 1'b0 || run_state !== 2'b01) begin n_bad++; $display("FAIL restart_flags: got w=%0d b=%0d st=%0d want 0/0/1", hit_wall, hit_body, run_state); end
  endtask

  task automatic test_wall();
    repeat (24) do_step(1'b0, U, 1'b0);
    n_cmp++; if (head_x !== 6'd34 || run_state !== 2'b01) begin n_bad++; $display("FAIL wall_approach: got x=%0d st=%0d want 34/1", head_x, run_state); end
    do_step(1'b0, U, 1'b0);
`ifdef SNAKE_BODY_ENGINE_WRAP_EN
    n_cmp++; if (head_x !== 6'd1 || hit_wall !== 1'b0 || run_state !== 2'b01) begin n_bad++; $display("FAIL wrap_right: got x=%0d w=%0d st=%0d want 1/0/1", head_x, hit_wall, run_state); end
`else
    n_cmp++; if (hit_wall !== 1'b1 || hit_body !== 1'b0) begin n_bad++; $display("FAIL wall_flags: got w=%0d b=%0d want 1/0", hit_wall, hit_body); end
    n_cmp++; if (run_state !== 2'b11 || head_x !== 6'd34 || head_y !== 6'd5) begin n_bad++; $display("FAIL wall_dead: got st=%0d (%0d,%0d) want 3 (34,5)", run_state, head_x, head_y); end
`endif
  endtask

  task automatic test_protect();
    do_start();
    repeat (24) do_step(1'b0, U, 1'b0);
    protect = 1'b1;
    do_step(1'b0, U, 1'b0);
`ifdef SNAKE_BODY_ENGINE_WRAP_EN
    n_cmp++; if (head_x !== 6'd1 || hit_wall !== 1'b0) begin n_bad++; $display("FAIL prot_wrap1: got x=%0d w=%0d want 1/0", head_x, hit_wall); end
    do_step(1'b0, U, 1'b0);
    n_cmp++; if (head_x !== 6'd2 || run_state !== 2'b01) begin n_bad++; $display("FAIL prot_wrap2: got x=%0d st=%0d want 2/1", head_x, run_state); end
`else
    n_cmp++; if (head_x !== 6'd34 || hit_wall !== 1'b0 || run_state !== 2'b01) begin n_bad++; $display("FAIL prot_clamp1: got x=%0d w=%0d st=%0d want 34/0/1", head_x, hit_wall, run_state); end
    do_step(1'b0, U, 1'b0);
    n_cmp++; if (head_x !== 6'd34 || hit_body !== 1'b0 || run_state !== 2'b01) begin n_bad++; $display("FAIL prot_clamp2: got x=%0d b=%0d st=%0d want 34/0/1", head_x, hit_body, run_state); end
    protect = 1'b0;
    do_step(1'b0, U, 1'b0);
    n_cmp++; if (hit_wall !== 1'b1 || run_state !== 2'b11) begin n_bad++; $display("FAIL prot_release: got w=%0d st=%0d want 1/3", hit_wall, run_state); end
`endif
    protect = 1'b0;
  endtask

  task automatic test_start_priority();
    pause = 1'b1; start = 1'b1; tick();
    start = 1'b0;
    n_cmp++; if (run_state !== 2'b01) begin n_bad++; $display("FAIL start_over_pause: got %0d want 1", run_state); end
    tick();
    n_cmp++; if (run_state !== 2'b10) begin n_bad++; $display("FAIL then_pause: got %0d want 2", run_state); end
    pause = 1'b0; tick();
    n_cmp++; if (run_state !== 2'b01 || head_x !== 6'd10) begin n_bad++; $display("FAIL then_resume: got st=%0d x=%0d want 1/10", run_state, head_x); end
  endtask

  // scenario sequence and final report
  initial begin
    test_reset();
    test_query();
    test_run_basic();
    test_dir_filter();
    test_grow();
    test_body_hit();
    test_wall();
    test_protect();
    test_start_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
